camera_scroll_ctrl: RTL and testbench

CAMERA_SCROLL_CTRL -- requirements
Module: camera_scroll_ctrl

---
 rtl/camera_scroll_ctrl.sv | 164 ++++++++++++++++
 tb/tb_camera_scroll_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/camera_scroll_ctrl.sv
// Horizontal camera scroll controller: edge-to-edge sweep with timed pauses at
// the bounds, a dead-zoned follow mode and a freeze mode, all paced by frame_tick.
module camera_scroll_ctrl #(
  parameter int W           = 10,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 639,
  parameter int HALF_W      = 4,
  parameter int CENTER      = 40,
  parameter int STEP        = 1,
  parameter int DEADZONE    = 16,
  parameter int HOLD_FRAMES = 30
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_tick,
  input  logic [1:0]   mode,
  input  logic [W-1:0] target_x,
  output logic [W-1:0] cam_x,
  output logic [1:0]   direction_cam,
  output logic         at_edge
);

  localparam int LO    = X_MIN + HALF_W;
  localparam int HI    = X_MAX - HALF_W;
  localparam int CNT_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic signed [W:0] LO_S    = (W+1)'(LO);
  localparam logic signed [W:0] HI_S    = (W+1)'(HI);
  localparam logic signed [W:0] STEP_S  = (W+1)'(STEP);
  localparam logic signed [W:0] DZ_P    = (W+1)'(DEADZONE);
  localparam logic signed [W:0] DZ_N    = (W+1)'(-DEADZONE);
  localparam logic [W-1:0]      LO_U    = W'(LO);
  localparam logic [W-1:0]      HI_U    = W'(HI);
  localparam logic [W-1:0]      CENTER_U = W'(CENTER);
  localparam logic [CNT_W-1:0]  HOLD_CNT = CNT_W'(HOLD_FRAMES);

  localparam logic [1:0] DIR_L    = 2'b00;
  localparam logic [1:0] DIR_R    = 2'b01;
  localparam logic [1:0] DIR_STOP = 2'b10;

  typedef enum logic [2:0] {MOVE_L, MOVE_R, PAUSE, FOLLOW, HOLD} state_t;

  state_t             state, state_nxt, eff;
  logic [W-1:0]       cam_nxt;
  logic [1:0]         dir_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               resume, resume_nxt;
  logic signed [W:0]  cam_s, dec_s, inc_s, err_s;

  function automatic logic [W-1:0] sat_lo(input logic signed [W:0] v);
    if (v <= LO_S) return LO_U;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_hi(input logic signed [W:0] v);
    if (v >= HI_S) return HI_U;
    return v[W-1:0];
  endfunction

  // One bit of headroom keeps every sum and difference from wrapping
  assign cam_s = $signed({1'b0, cam_x});
  assign dec_s = cam_s - STEP_S;
  assign inc_s = cam_s + STEP_S;
  assign err_s = $signed({1'b0, target_x}) - cam_s;

  always_comb begin
    state_nxt  = state;
    cam_nxt    = cam_x;
    dir_nxt    = direction_cam;
    cnt_nxt    = cnt;
    resume_nxt = resume;

    // Mode takes effect on the very tick it is sampled
    eff = state;
    if (mode[1])
      eff = HOLD;
    else if (mode[0])
      eff = FOLLOW;
    else if (state == FOLLOW || state == HOLD)
      eff = resume ? MOVE_R : MOVE_L;

    if (frame_tick) begin
      state_nxt = eff;
      case (eff)
        MOVE_L: begin
          if (dec_s <= LO_S) begin
            cam_nxt    = LO_U;
            cnt_nxt    = HOLD_CNT;
            resume_nxt = 1'b1;
            state_nxt  = PAUSE;
            dir_nxt    = DIR_STOP;
          end else begin
            cam_nxt = dec_s[W-1:0];
            dir_nxt = DIR_L;
          end
        end
        MOVE_R: begin
          if (inc_s >= HI_S) begin
            cam_nxt    = HI_U;
            cnt_nxt    = HOLD_CNT;
            resume_nxt = 1'b0;
            state_nxt  = PAUSE;
            dir_nxt    = DIR_STOP;
          end else begin
            cam_nxt = inc_s[W-1:0];
            dir_nxt = DIR_R;
          end
        end
        PAUSE: begin
          dir_nxt = DIR_STOP;
          if (cnt == '0) begin
            if (resume) begin
              cam_nxt   = sat_hi(inc_s);
              state_nxt = MOVE_R;
              dir_nxt   = DIR_R;
            end else begin
              cam_nxt   = sat_lo(dec_s);
              state_nxt = MOVE_L;
              dir_nxt   = DIR_L;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        FOLLOW: begin
          dir_nxt = DIR_STOP;
          if (err_s > DZ_P) begin
            resume_nxt = 1'b1;
            if (cam_x != HI_U) begin
              cam_nxt = sat_hi(inc_s);
              dir_nxt = DIR_R;
            end
          end else if (err_s < DZ_N) begin
            resume_nxt = 1'b0;
            if (cam_x != LO_U) begin
              cam_nxt = sat_lo(dec_s);
              dir_nxt = DIR_L;
            end
          end
        end
        default: dir_nxt = DIR_STOP;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= MOVE_L;
      cam_x         <= CENTER_U;
      direction_cam <= DIR_L;
      cnt           <= '0;
      resume        <= 1'b0;
    end else begin
      state         <= state_nxt;
      cam_x         <= cam_nxt;
      direction_cam <= dir_nxt;
      cnt           <= cnt_nxt;
      resume        <= resume_nxt;
    end
  end

  assign at_edge = (cam_x == LO_U) || (cam_x == HI_U);

endmodule

// File: tb/tb_camera_scroll_ctrl.sv
// Scoreboard bench for camera_scroll_ctrl: a default instance and a STEP=3,
// HOLD_FRAMES=0 instance share stimulus; expectations are queued per tick.
module tb_camera_scroll_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [1:0] mode;
  logic [9:0] target_x;
  logic [9:0] cam1, cam2;
  logic [1:0] dir1, dir2;
  logic       edge1, edge2;

  camera_scroll_ctrl u_dut1 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .mode(mode),
    .target_x(target_x), .cam_x(cam1), .direction_cam(dir1), .at_edge(edge1)
  );

  camera_scroll_ctrl #(.STEP(3), .HOLD_FRAMES(0)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .mode(mode),
    .target_x(target_x), .cam_x(cam2), .direction_cam(dir2), .at_edge(edge2)
  );

  typedef struct {
    int    n;
    int    x;
    int    d;
    int    e;
    string nm;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;
  int   n_issued = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic exp1(input int x, input int d, input int e, input string nm);
    exp_t t;
    t.n = n_issued + 1; t.x = x; t.d = d; t.e = e; t.nm = nm;
    q1.push_back(t);
  endtask

  task automatic exp2(input int x, input int d, input int e, input string nm);
    exp_t t;
    t.n = n_issued + 1; t.x = x; t.d = d; t.e = e; t.nm = nm;
    q2.push_back(t);
  endtask

  task automatic tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    n_issued++;
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk({nm, "_cam1"}, int'(cam1), 40);
    chk({nm, "_dir1"}, int'(dir1), 0);
    chk({nm, "_edge1"}, int'(edge1), 0);
    chk({nm, "_cam2"}, int'(cam2), 40);
    #1 Reset = 1'b0;
  endtask

  task automatic monitor();
    int   seen = 0;
    bit   t;
    exp_t e;
    forever begin
      @(posedge Clk);
      t = frame_tick && !Reset;
      @(negedge Clk);
      if (t) begin
        seen++;
        while (q1.size() > 0 && q1[0].n <= seen) begin
          e = q1.pop_front();
          chk({e.nm, "_x"}, int'(cam1), e.x);
          chk({e.nm, "_dir"}, int'(dir1), e.d);
          chk({e.nm, "_edge"}, int'(edge1), e.e);
        end
        while (q2.size() > 0 && q2[0].n <= seen) begin
          e = q2.pop_front();
          chk({e.nm, "_x"}, int'(cam2), e.x);
          chk({e.nm, "_dir"}, int'(dir2), e.d);
          chk({e.nm, "_edge"}, int'(edge2), e.e);
        end
      end
    end
  endtask

  task automatic stimulus();
    // Reset held with frame_tick high: nothing may move
    Reset = 1'b1; frame_tick = 1'b1; mode = 2'b00; target_x = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_cam1", int'(cam1), 40);
    chk("rst_dir1", int'(dir1), 0);
    chk("rst_edge1", int'(edge1), 0);
    chk("rst_cam2", int'(cam2), 40);
    chk("rst_dir2", int'(dir2), 0);
    frame_tick = 1'b0;
    Reset = 1'b0;

    // Sweep, edge pause, hold and resume
    for (int i = 1; i <= 66; i++) begin
      if (i <= 60 || i == 66) mode = 2'b00;
      else if (i <= 63)       mode = 2'b10;
      else                    mode = 2'b11;
      if (i == 1)  exp1(39, 0, 0, "sweep_first");
      if (i == 26) exp1(14, 2, 1, "sweep_edge");
      if (i == 40) exp1(14, 2, 1, "pause_mid");
      if (i == 56) exp1(14, 2, 1, "pause_last");
      if (i == 57) exp1(15, 1, 0, "pause_exit");
      if (i == 61) exp1(18, 2, 0, "hold_first");
      if (i == 65) exp1(18, 2, 0, "hold_mode11");
      if (i == 66) exp1(19, 1, 0, "hold_resume");
      if (i == 1)  exp2(37, 0, 0, "d2_first");
      if (i == 8)  exp2(16, 0, 0, "d2_near_lo");
      if (i == 9)  exp2(14, 2, 1, "d2_clamp_lo");
      if (i == 10) exp2(17, 1, 0, "d2_nohold_exit");
      tick();
    end

    pulse_reset("rst_sweep");

    // Follow: dead zone, settle, pin at HI, then sweep into a pause
    for (int j = 1; j <= 610; j++) begin
      mode = (j <= 608) ? 2'b01 : 2'b00;
      target_x = (j <= 10) ? 10'd50 : (j <= 56) ? 10'd100 : 10'd1023;
      if (j == 1)   exp1(40, 2, 0, "fol_dz_first");
      if (j == 10)  exp1(40, 2, 0, "fol_dz_last");
      if (j == 54)  exp1(84, 1, 0, "fol_last_step");
      if (j == 55)  exp1(84, 2, 0, "fol_settled");
      if (j == 607) exp1(635, 1, 1, "fol_reach_hi");
      if (j == 608) exp1(635, 2, 1, "fol_pinned");
      if (j == 609) exp1(635, 2, 1, "sweep_hi_pause");
      if (j == 610) exp1(635, 2, 1, "pause_hi_count");
      if (j == 26)  exp2(85, 2, 0, "d2_fol_settled");
      if (j == 239) exp2(634, 1, 0, "d2_fol_near_hi");
      if (j == 240) exp2(635, 1, 1, "d2_fol_clamp_hi");
      if (j == 608) exp2(635, 2, 1, "d2_fol_pinned");
      if (j == 609) exp2(635, 2, 1, "d2_hi_pause");
      if (j == 610) exp2(632, 0, 0, "d2_hi_exit");
      tick();
    end

    pulse_reset("rst_pause");

    mode = 2'b00;
    exp1(39, 0, 0, "post_rst_step");
    exp2(37, 0, 0, "d2_post_rst_step");
    tick();
    mode = 2'b01; target_x = 10'd0;
    exp1(38, 0, 0, "fol_left");
    exp2(34, 0, 0, "d2_fol_left");
    tick();

    repeat (3) @(negedge Clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
